// File: rtl/ksa16_mp_sequencer.sv
// ksa16_mp_sequencer
// Runs multi-precision add/subtract through one external 16-bit Kogge-Stone
// adder, one limb at a time, least-significant limb first. The adder has no
// carry-in, so the incoming carry (or the +1 of a two's-complement subtract)
// is applied in a second pass that adds 1 to the first-pass sum.
module ksa16_mp_sequencer #(
    parameter  int MAX_LIMBS = 8,
    localparam int IDX_W     = (MAX_LIMBS > 1) ? $clog2(MAX_LIMBS) : 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_last,
    output logic             out_carry,
    output logic             out_err,
    output logic [IDX_W-1:0] out_idx,
    output logic [15:0]      ksa_a,
    output logic [15:0]      ksa_b,
    input  logic [15:0]      ksa_sum,
    input  logic             ksa_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_LIMBS - 1);

    state_t           state_r;
    logic [15:0]      a_r;
    logic [15:0]      b_r;
    logic [15:0]      s_r;
    logic             c_r;
    logic             carry_r;
    logic             sub_r;
    logic             last_r;
    logic             op_active_r;
    logic [IDX_W-1:0] idx_r;

    logic             sub_s;
    logic             idx_max_s;
    logic             last_s;
    logic             accept_s;

    // Operation-level decode: which subtract flag applies and whether this limb closes the operation.
    always_comb begin
        sub_s     = 1'b0;
        idx_max_s = (idx_r == IDX_MAX);
        last_s    = last_r | idx_max_s;
        accept_s  = in_valid & in_ready;
        if (op_active_r) begin
            sub_s = sub_r;
        end else begin
            sub_s = in_sub;
        end
    end

    // Sequencer FSM: capture limb, first adder pass, optional +1 pass, hold result.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            a_r         <= 16'h0000;
            b_r         <= 16'h0000;
            s_r         <= 16'h0000;
            c_r         <= 1'b0;
            carry_r     <= 1'b0;
            sub_r       <= 1'b0;
            last_r      <= 1'b0;
            op_active_r <= 1'b0;
            idx_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r    <= in_a;
                        b_r    <= sub_s ? ~in_b : in_b;
                        last_r <= in_last;
                        if (!op_active_r) begin
                            sub_r       <= in_sub;
                            carry_r     <= in_sub;
                            idx_r       <= '0;
                            op_active_r <= 1'b1;
                        end else begin
                            sub_r <= sub_r;
                        end
                        state_r <= ADD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    s_r <= ksa_sum;
                    c_r <= ksa_cout;
                    if (carry_r) begin
                        state_r <= INC;
                    end else begin
                        state_r <= OUT;
                    end
                end
                INC: begin
                    // The +1 can only carry out when the first pass gave 0xFFFF,
                    // which means the first pass itself did not carry.
                    s_r     <= ksa_sum;
                    c_r     <= c_r | ksa_cout;
                    state_r <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (last_s) begin
                            op_active_r <= 1'b0;
                            carry_r     <= 1'b0;
                            idx_r       <= '0;
                        end else begin
                            carry_r <= c_r;
                            idx_r   <= idx_r + IDX_W'(1);
                        end
                        state_r <= IDLE;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output and adder-operand decode from the registered state; all zero while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = 16'h0000;
        out_last  = 1'b0;
        out_carry = 1'b0;
        out_err   = 1'b0;
        out_idx   = '0;
        ksa_a     = 16'h0000;
        ksa_b     = 16'h0000;
        if (wb_rst_i) begin
            in_ready = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready = 1'b1;
                end
                ADD: begin
                    ksa_a = a_r;
                    ksa_b = b_r;
                end
                INC: begin
                    ksa_a = s_r;
                    ksa_b = 16'h0001;
                end
                OUT: begin
                    out_valid = 1'b1;
                    out_sum   = s_r;
                    out_carry = c_r;
                    out_idx   = idx_r;
                    out_last  = last_s;
                    out_err   = idx_max_s & ~last_r;
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa16_mp_sequencer.sv
// Self-checking bench for ksa16_mp_sequencer: directed cases plus random limbs
// against an arithmetic model of multi-precision add/subtract.
module tb_ksa16_mp_sequencer;

    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0000;
    logic [15:0] in_b = 16'h0000;
    logic        in_sub = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_last;
    logic        out_carry;
    logic        out_err;
    logic [2:0]  out_idx;
    logic [15:0] ksa_a;
    logic [15:0] ksa_b;
    logic [15:0] ksa_sum;
    logic        ksa_cout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (operation level)
    logic m_active = 1'b0;
    logic m_sub    = 1'b0;
    logic m_carry  = 1'b0;
    int   m_idx    = 0;

    always #5 clk = ~clk;

    // Stand-in for the external combinational adder
    assign {ksa_cout, ksa_sum} = {1'b0, ksa_a} + {1'b0, ksa_b};

    ksa16_mp_sequencer #(.MAX_LIMBS(MAXL)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_last (out_last),
        .out_carry(out_carry),
        .out_err  (out_err),
        .out_idx  (out_idx),
        .ksa_a    (ksa_a),
        .ksa_b    (ksa_b),
        .ksa_sum  (ksa_sum),
        .ksa_cout (ksa_cout)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Offer one limb, compare the result against the model, stall, then consume it.
    task automatic do_limb(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic last, input int stall);
        logic [15:0] bb;
        logic [16:0] full;
        int          exp_lat;
        logic        exp_last;
        logic        exp_err;
        int          exp_idx;
        int          lat;
        int          w;
        logic [15:0] h_sum;

        // model
        if (!m_active) begin
            m_sub    = sub;
            m_carry  = sub;
            m_idx    = 0;
            m_active = 1'b1;
        end
        bb       = m_sub ? ~b : b;
        full     = {1'b0, a} + {1'b0, bb} + {16'h0000, m_carry};
        exp_lat  = m_carry ? 3 : 2;
        exp_last = last || (m_idx == MAXL - 1);
        exp_err  = !last && (m_idx == MAXL - 1);
        exp_idx  = m_idx;

        // drive
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_last   = last;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sub   = $urandom_range(0, 1);
        in_last  = $urandom_range(0, 1);

        lat = 0;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (lat == 1) begin
                check_eq("ksa_a_add", {16'd0, ksa_a}, {16'd0, a});
                check_eq("ksa_b_add", {16'd0, ksa_b}, {16'd0, bb});
            end
            if (lat == 2) begin
                check_eq("ksa_b_inc", {16'd0, ksa_b}, 32'h0000_0001);
            end
            check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
        end
        check_eq("latency", lat, exp_lat);
        check_eq("out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("out_sum", {16'd0, out_sum}, {16'd0, full[15:0]});
        check_eq("out_carry", {31'd0, out_carry}, {31'd0, full[16]});
        check_eq("out_last", {31'd0, out_last}, {31'd0, exp_last});
        check_eq("out_err", {31'd0, out_err}, {31'd0, exp_err});
        check_eq("out_idx", {29'd0, out_idx}, exp_idx);
        h_sum = out_sum;

        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
            check_eq("stall_sum", {16'd0, out_sum}, {16'd0, h_sum});
            check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("after_valid", {31'd0, out_valid}, 32'd0);
        check_eq("after_ready", {31'd0, in_ready}, 32'd1);

        // model update
        if (exp_last) begin
            m_active = 1'b0;
            m_carry  = 1'b0;
            m_idx    = 0;
        end else begin
            m_carry = full[16];
            m_idx++;
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_outs", {13'd0, out_sum, out_last, out_carry, out_err}, 32'd0);
        check_eq("rst_ksa", {ksa_a, ksa_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", {31'd0, in_ready}, 32'd1);

        // 1: single limb
        do_limb(16'h1234, 16'h4321, 1'b0, 1'b1, 0);
        // 2: two limbs with inter-limb carry
        do_limb(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_limb(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
        // 3: subtracts
        do_limb(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        do_limb(16'h1234, 16'h0000, 1'b1, 1'b1, 0);
        // 4: backpressure
        do_limb(16'h1234, 16'h4321, 1'b0, 1'b1, 5);
        // 5: force-close at MAX_LIMBS, then a fresh subtract
        for (int i = 0; i < MAXL; i++) do_limb(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        do_limb(16'h0003, 16'h0001, 1'b1, 1'b1, 0);

        // 6: reset during INC of limb1
        do_limb(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'h0000;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);           // ADD -> INC
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_active = 1'b0;
        m_carry  = 1'b0;
        m_idx    = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("midrst_noout", {31'd0, out_valid}, 32'd0);
            check_eq("midrst_idle", {31'd0, in_ready}, 32'd1);
        end
        do_limb(16'h0001, 16'h0001, 1'b0, 1'b1, 0);

        // random limbs
        for (int i = 0; i < 150; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h0000;
            do_limb(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa16_mp_sequencer.md
Name: ksa16_mp_sequencer

Overview:
Sequencer that runs multi-precision add/subtract on the shared 16-bit Kogge-Stone adder, one 16-bit limb at a time, LS limb first. The adder has no carry-in, so the block folds inter-limb carry (and the subtract +1) into a second adder pass. It sits between a streaming limb source (Wishbone-side logic in the Caravel user area) and a single combinational KSA16 instance, which is instantiated outside this block.

Parameters:
MAX_LIMBS, 8, maximum limbs per operation (128-bit); the limb index counter is clog2(MAX_LIMBS) bits wide.

Ports:
wb_clk_i     input   1   clock
wb_rst_i     input   1   synchronous active-high reset
in_valid     input   1   limb offered
in_ready     output  1   limb accepted when in_valid & in_ready
in_a         input   16  operand A limb
in_b         input   16  operand B limb
in_sub       input   1   1 = A-B; sampled only on the first limb of an operation
in_last      input   1   final (MS) limb of the operation
out_valid    output  1   result limb available
out_ready    input   1   consumer accepts result
out_sum      output  16  result limb
out_last     output  1   final limb of the operation
out_carry    output  1   carry-out of this limb; on the last limb 1 = no borrow for subtract
out_err      output  1   operation was force-terminated at MAX_LIMBS
out_idx      output  clog2(MAX_LIMBS)  limb index of out_sum
ksa_a        output  16  to adder operand a
ksa_b        output  16  to adder operand b
ksa_sum      input   16  from adder sum
ksa_cout     input   1   from adder cout

Behaviour:
- One clock; reset is synchronous and active-high. Clock and reset ports are wb_clk_i and wb_rst_i.
- Reset: state=IDLE, carry_r=0, op_active=0, idx=0. All outputs are 0, including in_ready while wb_rst_i=1. ksa_a/ksa_b are 0.
- States: IDLE, ADD, INC, OUT.
- IDLE:
  - in_ready=1.
  - On accept: a_r<=in_a.
  - b_r<=in_b, or ~in_b if the operation is a subtract.
  - If op_active=0 (first limb): sub_r<=in_sub, carry_r<=in_sub, idx<=0, op_active<=1. Otherwise sub_r is kept and the limb uses the held sub_r.
  - last_r<=in_last. Next state is ADD.
- ADD:
  - ksa_a=a_r, ksa_b=b_r.
  - s_r<=ksa_sum, c_r<=ksa_cout.
  - Next state is INC if carry_r=1, else OUT.
- INC:
  - ksa_a=s_r, ksa_b=16'h0001.
  - s_r<=ksa_sum, c_r<=c_r|ksa_cout.
  - Next state is OUT.
- OUT:
  - out_valid=1. out_sum=s_r, out_carry=c_r, out_idx=idx, out_last=last_r|(idx==MAX_LIMBS-1).
  - out_err=1 only when idx==MAX_LIMBS-1 and last_r=0.
  - Outputs are held stable while out_ready=0.
  - On out_ready: carry_r<=c_r and idx<=idx+1. Next state is IDLE.
  - If out_last: op_active<=0, carry_r<=0, idx<=0.
- ksa_a/ksa_b are combinational from state; they are 0 in IDLE and OUT.
- Latency from accept to out_valid: 2 cycles (no carry in), 3 cycles (carry in).
- Throughput: one limb per 3 or 4 cycles. No overlap; in_ready=0 outside IDLE.
- Carry arithmetic: c1|c2 never exceeds 1 carry, because c2=1 only when the ADD sum was 0xFFFF, which implies c1=0.
- MAX_LIMBS boundary: the operation is force-closed (out_last=1, out_err=1). The next accepted limb starts a new operation and samples in_sub.
- Reset mid-operation: any in-flight limb and accumulated carry are discarded, with no output. Same values as the reset bullet above.
- in_sub/in_last are ignored when in_valid=0. in_sub is ignored on non-first limbs.

Test Plan:
1. Single limb: 0x1234+0x4321, last=1.
   -> out_sum=0x5555, carry=0, last=1, idx=0; out_valid 2 cycles after accept; no INC state.
2. Two limbs: limb0 0xFFFF+0x0001, limb1 0xFFFF+0x0000 last.
   -> limb0: sum=0x0000, carry=1.
   -> limb1 takes INC path: sum=0x0000, carry=1, valid 3 cycles after accept.
3. Subtract, single limb: 0x0005-0x0007.
   -> ADD gives 0xFFFD; INC gives out_sum=0xFFFE, out_carry=0 (borrow).
   -> 0x1234-0x0000 -> out_sum=0x1234, carry=1.
4. Backpressure: out_ready=0 for 5 cycles in case 1.
   -> out_* stable, in_ready=0 throughout.
   -> Accept on the 6th cycle; then IDLE, in_ready=1.
5. MAX_LIMBS=8: 8 limbs of 0x0001+0x0001 with in_last=0.
   -> 8th output: sum=0x0002, last=1, err=1.
   -> A 9th limb with in_sub=1 is treated as a new subtract (idx=0).
6. Reset mid-op: assert wb_rst_i during INC of limb1 from case 2.
   -> No output. After release: in_ready=1; a new 0x0001+0x0001 gives sum 0x0002, carry 0.
